result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 84 ++++++++
 tb/tb_result_collector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// Ping-pong result collector: gathers M results per vector into one of two banks
// and streams each completed bank downstream, optionally applying ReLU on capture.
module result_collector #(
  parameter int M    = 8,
  parameter int T    = 12,
  parameter bit RELU = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [T-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(M - 1);

  logic [T-1:0]  mem [2][M];
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic          in_fire;
  logic          out_fire;
  logic [T-1:0]  store_data;

  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_data  = mem[rd_bank][rd_cnt];
  assign out_last  = out_valid && (rd_cnt == LAST_IDX);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    store_data = in_data;
    if (RELU && in_data[T-1]) begin
      store_data = '0;
    end
  end

  // Bank storage carries no reset; stale contents are unreachable once flags clear.
  always_ff @(posedge clk) begin
    if (reset && in_fire) begin
      mem[wr_bank][wr_cnt] <= store_data;
    end
  end

  // A write can only target an empty bank and a read only a full one, so the
  // set and clear below always hit different bits of full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      if (in_fire) begin
        if (wr_cnt == LAST_IDX) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (out_fire) begin
        if (rd_cnt == LAST_IDX) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          rd_cnt        <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: a ReLU and a pass-through instance share
// stimulus; a vector-level model predicts handshakes and queued expected data.
module tb_result_collector;

  localparam int M = 4;
  localparam int T = 12;

  logic         clk;
  logic         reset;
  logic [T-1:0] in_data;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready_r, out_valid_r, out_last_r;
  logic [T-1:0] out_data_r;
  logic         in_ready_w, out_valid_w, out_last_w;
  logic [T-1:0] out_data_w;

  logic [T-1:0] exp_relu[$];
  logic [T-1:0] exp_raw[$];
  int acc_count;
  int out_count;
  int checks;
  int errors;
  bit rand_done;

  result_collector #(.M(M), .T(T), .RELU(1'b1)) u_dut_relu (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_r), .out_data(out_data_r), .out_valid(out_valid_r),
    .out_ready(out_ready), .out_last(out_last_r)
  );

  result_collector #(.M(M), .T(T), .RELU(1'b0)) u_dut_raw (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w), .out_data(out_data_w), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_last(out_last_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [T-1:0] relu_ref(input logic [T-1:0] d);
    return ($signed(d) < 0) ? '0 : d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offers one element and records its expected result once it is accepted.
  task automatic applyStimulus(input logic [T-1:0] d);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready_r) begin
        @(posedge clk);
        exp_relu.push_back(relu_ref(d));
        exp_raw.push_back(d);
        acc_count++;
        accepted = 1'b1;
        #1;
      end
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic applyReset();
    sync();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic waitDrain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_relu.size() != 0; i++) begin
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain_empty", exp_relu.size(), 32'd0);
  endtask

  // Monitor: model holds complete-but-undrained vectors; at most two fit.
  always @(negedge clk) begin
    int held;
    bit exp_valid;
    bit exp_last;
    if (!reset) begin
      exp_relu.delete();
      exp_raw.delete();
      acc_count = 0;
      out_count = 0;
    end else begin
      held      = acc_count / M - out_count / M;
      exp_valid = (held >= 1);
      exp_last  = exp_valid && ((out_count % M) == M - 1);
      checkOutput("in_ready_relu", in_ready_r, (held < 2));
      checkOutput("in_ready_raw", in_ready_w, (held < 2));
      checkOutput("out_valid_relu", out_valid_r, exp_valid);
      checkOutput("out_valid_raw", out_valid_w, exp_valid);
      checkOutput("out_last_relu", out_last_r, exp_last);
      checkOutput("out_last_raw", out_last_w, exp_last);
      if (exp_valid) begin
        if (exp_relu.size() == 0) begin
          checkOutput("queue_underflow", 32'd0, 32'd1);
        end else begin
          checkOutput("out_data_relu", out_data_r, exp_relu[0]);
          checkOutput("out_data_raw", out_data_w, exp_raw[0]);
          if (out_ready) begin
            void'(exp_relu.pop_front());
            void'(exp_raw.pop_front());
            out_count++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rand_done = 1'b0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    @(negedge clk);
    checkOutput("reset_in_ready", in_ready_r, 32'd1);
    checkOutput("reset_out_valid", out_valid_r, 32'd0);
    checkOutput("reset_out_last", out_last_r, 32'd0);
    sync();

    $display("[TB] directed ReLU vector");
    out_ready = 1'b1;
    applyStimulus(12'd5);
    applyStimulus(-12'sd3);
    applyStimulus(12'd100);
    applyStimulus(12'd0);
    waitDrain();

    $display("[TB] back-pressure with both banks full");
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 9; i++) applyStimulus(T'(i * 37 + 11));
      end
      begin
        repeat (16) @(posedge clk);
        #1;
        checkOutput("both_full_in_ready", in_ready_r, 32'd0);
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 3; i++) applyStimulus(-T'(i + 1));
    waitDrain();

    $display("[TB] streaming across bank swap");
    out_ready = 1'b1;
    for (int i = 0; i < 3 * M; i++) applyStimulus(T'(i * 200 + 1));
    waitDrain();

    $display("[TB] reset discards partial vector");
    out_ready = 1'b0;
    applyStimulus(12'd7);
    applyStimulus(12'd8);
    applyReset();
    @(negedge clk);
    checkOutput("rst2_out_valid", out_valid_r, 32'd0);
    checkOutput("rst2_in_ready", in_ready_r, 32'd1);
    sync();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(T'(i));
    waitDrain();

    $display("[TB] randomized traffic");
    fork
      begin
        for (int i = 0; i < 25 * M; i++) begin
          if ($urandom_range(0, 3) == 0) sync();
          applyStimulus(T'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
